// File: rtl/bitmap_if.sv
// Handshake bundle between bitmap producer, bitmap_encoder and index consumer.
// out_zero exists only when BITMAP_ZERO_FLAG_EN is defined.
interface bitmap_if #(
    parameter int SIZE  = 2,
    parameter int IN_SZ = 4
);
    logic [IN_SZ-1:0] in_vec;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  out_index;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
`ifdef BITMAP_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_index, out_valid, out_last, out_zero
    );
    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_index, out_valid, out_last, out_zero
    );
`else
    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_index, out_valid, out_last
    );
    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_index, out_valid, out_last
    );
`endif
endinterface

// File: rtl/bitmap_encoder.sv
// Sequential priority encoder: emits the index of every set bit of a bitmap, lowest first.
// Optional BITMAP_ZERO_FLAG_EN: an all-zero bitmap produces one beat flagged by out_zero.
module bitmap_encoder #(
    parameter int SIZE  = 2,
    parameter int IN_SZ = 4
) (
    input  logic     clk,
    input  logic     rst,
    bitmap_if.slave  bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IN_SZ-1:0] r_pend;
    logic [IN_SZ-1:0] w_pend_low_clr;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [SIZE-1:0]  w_out_index;
    logic             w_out_last;
    logic             w_accept;
    logic             w_out_fire;

    // x & (x-1) drops the lowest set bit; zero result means at most one bit was set.
    assign w_pend_low_clr = r_pend & (r_pend - IN_SZ'(1));
    assign w_accept       = w_in_ready && bus.in_valid;
    assign w_out_fire     = w_out_valid && bus.out_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef BITMAP_ZERO_FLAG_EN
                    w_state_nxt = S_EMIT;
`else
                    w_state_nxt = (bus.in_vec != '0) ? S_EMIT : S_IDLE;
`endif
                end
            end
            S_EMIT: begin
                if (w_out_fire && w_out_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == S_IDLE) && !rst;
        w_out_valid = (r_state == S_EMIT);
        w_out_last  = (r_state == S_EMIT) && (w_pend_low_clr == '0);
        w_out_index = '0;
        for (int k = IN_SZ - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_out_index = SIZE'(k);
            end
        end
    end

    // r_pend is only non-zero in EMIT, so the IDLE outputs fall back to their reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend <= bus.in_vec;
        end else if (w_out_fire) begin
            r_pend <= w_pend_low_clr;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_index = w_out_index;
    assign bus.out_last  = w_out_last;
`ifdef BITMAP_ZERO_FLAG_EN
    assign bus.out_zero  = (r_state == S_EMIT) && (r_pend == '0);
`endif

endmodule

// File: tb/tb_bitmap_encoder.sv
// Bench for bitmap_encoder: directed test-plan cases with literal expectations, then random
// traffic compared every cycle against a queue-of-expected-beats model.
module tb_bitmap_encoder;
    localparam int SIZE  = 2;
    localparam int IN_SZ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitmap_if #(.SIZE(SIZE), .IN_SZ(IN_SZ)) bus ();

    bitmap_encoder #(.SIZE(SIZE), .IN_SZ(IN_SZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int idx;
        bit zero;
    } beat_t;

    beat_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: while beats are queued the block is emitting; an empty queue means IDLE.
    always @(posedge clk) begin
        beat_t b;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (bus.in_valid) begin
                if (bus.in_vec != '0) begin
                    for (int k = 0; k < IN_SZ; k++) begin
                        if (bus.in_vec[k]) begin
                            b.idx  = k;
                            b.zero = 1'b0;
                            exp_q.push_back(b);
                        end
                    end
                end
`ifdef BITMAP_ZERO_FLAG_EN
                else begin
                    b.idx  = 0;
                    b.zero = 1'b1;
                    exp_q.push_back(b);
                end
`endif
            end
        end else if (bus.out_ready) begin
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready", 32'(bus.in_ready), 32'(!rst && exp_q.size() == 0));
        check("cmp_out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("cmp_out_index", 32'(bus.out_index), 32'(exp_q[0].idx));
            check("cmp_out_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
`ifdef BITMAP_ZERO_FLAG_EN
            check("cmp_out_zero", 32'(bus.out_zero), 32'(exp_q[0].zero));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [IN_SZ-1:0] v);
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string name, input int idx, input bit last);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_index"}, 32'(bus.out_index), 32'(idx));
        check({name, "_last"}, 32'(bus.out_last), 32'(last));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        step();
        step();

        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_index", 32'(bus.out_index), 32'd0);
        check("reset_out_last", 32'(bus.out_last), 32'd0);
`ifdef BITMAP_ZERO_FLAG_EN
        check("reset_out_zero", 32'(bus.out_zero), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Single bit
        send(4'b0100);
        expect_beat("single", 2, 1'b1);
        step();
        check("single_in_ready", 32'(bus.in_ready), 32'd1);
        check("single_done", 32'(bus.out_valid), 32'd0);

        // All bits, one beat per cycle
        send(4'b1111);
        for (int i = 0; i < 4; i++) begin
            expect_beat("all", i, i == 3);
            step();
        end
        check("all_done", 32'(bus.out_valid), 32'd0);

        // Backpressure with in_vec churn that must be ignored
        bus.out_ready = 1'b0;
        send(4'b1010);
        expect_beat("bp_hold0", 1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_vec   = 4'b0101;
        step();
        expect_beat("bp_hold1", 1, 1'b0);
        bus.in_vec = 4'b1111;
        step();
        expect_beat("bp_hold2", 1, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        expect_beat("bp_last", 3, 1'b1);
        step();
        check("bp_done", 32'(bus.out_valid), 32'd0);
        check("bp_in_ready", 32'(bus.in_ready), 32'd1);

        // Zero bitmap
        send(4'b0000);
`ifdef BITMAP_ZERO_FLAG_EN
        expect_beat("zero", 0, 1'b1);
        check("zero_flag", 32'(bus.out_zero), 32'd1);
        step();
        check("zero_done", 32'(bus.out_valid), 32'd0);
`else
        check("zero_no_beat", 32'(bus.out_valid), 32'd0);
        check("zero_in_ready", 32'(bus.in_ready), 32'd1);
`endif

        // Reset mid-bitmap
        send(4'b1011);
        expect_beat("rst_first", 0, 1'b0);
        rst = 1'b1;
        step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        step();
        check("rst_after_valid", 32'(bus.out_valid), 32'd0);
        send(4'b1000);
        expect_beat("rst_next", 3, 1'b1);
        step();
        check("rst_next_done", 32'(bus.out_valid), 32'd0);

        // Decoder round trip
        for (int k = 0; k < 4; k++) begin
            logic [IN_SZ-1:0] onehot;
            onehot = IN_SZ'(1) << k;
            send(onehot);
            expect_beat("roundtrip", k, 1'b1);
            step();
        end

        // Random traffic, checked by the per-cycle compare process
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 49) == 0);
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.in_vec    = IN_SZ'($urandom_range(0, (1 << IN_SZ) - 1));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) step();
        check("drain_idle", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
